// File: rtl/icache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
`timescale 1ns/1ps
package icache_pkg;

  localparam int MemAddrBus      = 32;
  localparam int INSTWide        = 64;
  localparam int ICacheIndexW    = 6;
  localparam int ICacheLineBeats = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MISS_REQ = 3'd2,
    S_REFILL   = 3'd3,
    S_RESP     = 3'd4
  } icache_state_e;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundles of the instruction cache.
`timescale 1ns/1ps
interface icache_if #(parameter int ADDR_W = 32);

  logic              cache_req;
  logic [ADDR_W-1:0] addr_inst;
  logic              cache_ready;
  logic              cache_valid;
  logic [63:0]       inst_i;
  logic              fence_i;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;
  logic              mem_rlast;

  modport fetch_master (output cache_req, addr_inst, fence_i,
                        input  cache_ready, cache_valid, inst_i);
  modport fetch_slave  (input  cache_req, addr_inst, fence_i,
                        output cache_ready, cache_valid, inst_i);
  modport mem_master   (output mem_req, mem_addr,
                        input  mem_ready, mem_rvalid, mem_rdata, mem_rlast);
  modport mem_slave    (input  mem_req, mem_addr,
                        output mem_ready, mem_rvalid, mem_rdata, mem_rlast);

endinterface

// File: rtl/icache_data_ram.sv
// Line data storage: flop array, combinational read, single write port.
`timescale 1ns/1ps
module icache_data_ram #(
  parameter int INDEX_W = 6,
  parameter int BEAT_W  = 1,
  parameter int DATA_W  = 64
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [BEAT_W-1:0]  rd_beat_i,
  output logic [DATA_W-1:0]  rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [BEAT_W-1:0]  wr_beat_i,
  input  logic [DATA_W-1:0]  wr_data_i
);

  localparam int WORDS = 1 << (INDEX_W + BEAT_W);

  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[{wr_index_i, wr_beat_i}] <= wr_data_i;
  end

  assign rd_data_o = mem_q[{rd_index_i, rd_beat_i}];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 2-beat line refill and fence.i flush.
`timescale 1ns/1ps
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_W     = MemAddrBus,
  parameter int INDEX_W    = ICacheIndexW,
  parameter int LINE_BEATS = ICacheLineBeats
) (
  input  logic           clk,
  input  logic           rst,
  icache_if.fetch_slave  fetch,
  icache_if.mem_master   mem
);

  localparam int TAG_W  = ADDR_W - INDEX_W - 4;
  localparam int LINES  = 1 << INDEX_W;
  localparam int BEAT_W = $clog2(LINE_BEATS);

  icache_state_e        state_q;
  logic [TAG_W-1:0]     req_tag_q;
  logic [INDEX_W-1:0]   req_index_q;
  logic [BEAT_W-1:0]    req_beat_q;
  logic [BEAT_W-1:0]    beat_cnt_q;
  logic [INSTWide-1:0]  resp_q;
  logic [LINES-1:0]     valid_q;
  logic                 flush_pending_q;
  logic [TAG_W-1:0]     tag_mem_q [LINES];

  logic                 hit;
  logic                 lookup_hit;
  logic                 flush_now;
  logic                 handshake;
  logic                 refill_beat;
  logic                 flush_pending_d;
  logic [INSTWide-1:0]  ram_rdata;

  assign hit         = valid_q[req_index_q] && (tag_mem_q[req_index_q] == req_tag_q);
  assign lookup_hit  = (state_q == S_LOOKUP) && hit;
  assign flush_now   = (state_q == S_IDLE) && flush_pending_q;
  assign refill_beat = (state_q == S_REFILL) && mem.mem_rvalid;

  // A pending flush also blocks back-to-back hits so it lands before the next request.
  assign fetch.cache_ready = rst && !flush_pending_q &&
                             ((state_q == S_IDLE) || lookup_hit);
  assign handshake         = fetch.cache_req && fetch.cache_ready;
  assign fetch.cache_valid = lookup_hit || (state_q == S_RESP);
  assign fetch.inst_i      = (state_q == S_LOOKUP) ? ram_rdata : resp_q;

  assign mem.mem_req  = (state_q == S_MISS_REQ);
  assign mem.mem_addr = {req_tag_q, req_index_q, 4'b0};

  assign flush_pending_d = fetch.fence_i | (flush_pending_q & ~flush_now);

  icache_data_ram #(
    .INDEX_W (INDEX_W),
    .BEAT_W  (BEAT_W),
    .DATA_W  (INSTWide)
  ) u_data_ram (
    .clk        (clk),
    .rd_index_i (req_index_q),
    .rd_beat_i  (req_beat_q),
    .rd_data_o  (ram_rdata),
    .we_i       (refill_beat),
    .wr_index_i (req_index_q),
    .wr_beat_i  (beat_cnt_q),
    .wr_data_i  (mem.mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (refill_beat && mem.mem_rlast) tag_mem_q[req_index_q] <= req_tag_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      req_tag_q       <= '0;
      req_index_q     <= '0;
      req_beat_q      <= '0;
      beat_cnt_q      <= '0;
      resp_q          <= '0;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      flush_pending_q <= flush_pending_d;
      if (flush_now) valid_q <= '0;
      if (handshake) begin
        req_tag_q   <= fetch.addr_inst[ADDR_W-1:INDEX_W+4];
        req_index_q <= fetch.addr_inst[INDEX_W+3:4];
        req_beat_q  <= fetch.addr_inst[3 +: BEAT_W];
      end
      case (state_q)
        S_IDLE: begin
          if (handshake) state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (hit) begin
            state_q <= handshake ? S_LOOKUP : S_IDLE;
          end else begin
            state_q    <= S_MISS_REQ;
            beat_cnt_q <= '0;
          end
        end
        S_MISS_REQ: begin
          if (mem.mem_ready) state_q <= S_REFILL;
        end
        S_REFILL: begin
          if (mem.mem_rvalid) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            if (beat_cnt_q == req_beat_q) resp_q <= mem.mem_rdata;
            if (mem.mem_rlast) begin
              valid_q[req_index_q] <= 1'b1;
              state_q              <= S_RESP;
            end
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, conflicts, gapped beats, flush, reset.
`timescale 1ns/1ps
module tb_icache;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  icache_if #(.ADDR_W(32)) bus ();

  icache dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus),
    .mem   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  localparam logic [63:0] D_LO = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D_HI = 64'h5555_6666_7777_8888;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("pass %s: %h", tag, got);
    end
  endtask

  // Entered and left at posedge+1; returns with the cache in LOOKUP.
  task automatic start_fetch(input logic [31:0] a);
    int n;
    n = 0;
    bus.cache_req = 1'b1;
    bus.addr_inst = a;
    @(negedge clk);
    while (!bus.cache_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", bus.cache_ready, 1);
    @(posedge clk); #1;
    bus.cache_req = 1'b0;
  endtask

  task automatic expect_hit(input logic [63:0] exp);
    @(negedge clk);
    check("hit_valid", bus.cache_valid, 1);
    check("hit_data", bus.inst_i, exp);
    check("hit_no_memreq", bus.mem_req, 0);
    @(posedge clk); #1;
  endtask

  task automatic expect_miss();
    @(negedge clk);
    check("miss_valid", bus.cache_valid, 0);
    check("miss_ready", bus.cache_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic serve_refill(input logic [31:0] exp_addr, input logic [63:0] d0,
                              input logic [63:0] d1, input int ready_dly, input int gap,
                              input bit fence_mid, input logic [63:0] exp);
    @(negedge clk);
    check("mem_req", bus.mem_req, 1);
    check("mem_addr", bus.mem_addr, exp_addr);
    for (int i = 0; i < ready_dly; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("mem_req_hold", bus.mem_req, 1);
      check("mem_addr_hold", bus.mem_addr, exp_addr);
    end
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = d0;
    bus.mem_rlast  = 1'b0;
    bus.fence_i    = fence_mid;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.fence_i    = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = d1;
    bus.mem_rlast  = 1'b1;
    @(negedge clk);
    check("no_early_valid", bus.cache_valid, 0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
    @(negedge clk);
    check("resp_valid", bus.cache_valid, 1);
    check("resp_data", bus.inst_i, exp);
    check("resp_ready", bus.cache_ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.cache_req  = 1'b0;
    bus.addr_inst  = '0;
    bus.fence_i    = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_rlast  = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;

    @(negedge clk);
    check("rst_ready", bus.cache_ready, 0);
    check("rst_valid", bus.cache_valid, 0);
    check("rst_memreq", bus.mem_req, 0);
    check("rst_inst", bus.inst_i, 0);
    check("rst_memaddr", bus.mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.cache_ready, 1);
    @(posedge clk); #1;

    // Cold miss on beat 0
    start_fetch(32'h8000_0004);
    expect_miss();
    serve_refill(32'h8000_0000, D_LO, D_HI, 0, 0, 1'b0, D_LO);

    // Back-to-back hit stream
    bus.cache_req = 1'b1;
    bus.addr_inst = 32'h8000_0000;
    @(negedge clk);
    check("stream_ready", bus.cache_ready, 1);
    @(posedge clk); #1;
    bus.addr_inst = 32'h8000_0008;
    @(negedge clk);
    check("stream0_valid", bus.cache_valid, 1);
    check("stream0_data", bus.inst_i, D_LO);
    check("stream0_ready", bus.cache_ready, 1);
    @(posedge clk); #1;
    bus.addr_inst = 32'h8000_0000;
    @(negedge clk);
    check("stream1_valid", bus.cache_valid, 1);
    check("stream1_data", bus.inst_i, D_HI);
    check("stream1_memreq", bus.mem_req, 0);
    @(posedge clk); #1;
    bus.cache_req = 1'b0;
    @(negedge clk);
    check("stream2_valid", bus.cache_valid, 1);
    check("stream2_data", bus.inst_i, D_LO);
    @(posedge clk); #1;
    @(negedge clk);
    check("stream_idle_valid", bus.cache_valid, 0);
    @(posedge clk); #1;

    // Conflict miss on the same index, then the original line misses again
    start_fetch(32'h8000_0400);
    expect_miss();
    serve_refill(32'h8000_0400, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002,
                 0, 0, 1'b0, 64'hAAAA_0000_0000_0001);
    start_fetch(32'h8000_0000);
    expect_miss();
    serve_refill(32'h8000_0000, D_LO, D_HI, 0, 0, 1'b0, D_LO);

    // Beat 1 request with delayed mem_ready and gapped beats
    start_fetch(32'h8000_0018);
    expect_miss();
    serve_refill(32'h8000_0010, 64'hB0B0_B0B0_B0B0_B0B0, 64'hB1B1_B1B1_B1B1_B1B1,
                 2, 3, 1'b0, 64'hB1B1_B1B1_B1B1_B1B1);
    start_fetch(32'h8000_001C);
    expect_hit(64'hB1B1_B1B1_B1B1_B1B1);

    // Flush in IDLE, then a flush arriving mid-refill
    bus.fence_i = 1'b1;
    @(posedge clk); #1;
    bus.fence_i = 1'b0;
    @(negedge clk);
    check("flush_ready_low", bus.cache_ready, 0);
    @(posedge clk); #1;
    start_fetch(32'h8000_0000);
    expect_miss();
    serve_refill(32'h8000_0000, 64'hC0C0_C0C0_C0C0_C0C0, 64'hC1C1_C1C1_C1C1_C1C1,
                 0, 1, 1'b1, 64'hC0C0_C0C0_C0C0_C0C0);
    @(negedge clk);
    check("deferred_flush_ready", bus.cache_ready, 0);
    @(posedge clk); #1;
    start_fetch(32'h8000_0000);
    expect_miss();
    serve_refill(32'h8000_0000, D_LO, D_HI, 0, 0, 1'b0, D_LO);

    // Reset after the first refill beat
    bus.fence_i = 1'b1;
    @(posedge clk); #1;
    bus.fence_i = 1'b0;
    start_fetch(32'h8000_0000);
    expect_miss();
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hEEEE_EEEE_EEEE_EEEE;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", bus.cache_ready, 0);
    check("midrst_valid", bus.cache_valid, 0);
    check("midrst_memreq", bus.mem_req, 0);
    check("midrst_inst", bus.inst_i, 0);
    check("midrst_memaddr", bus.mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    start_fetch(32'h8000_0000);
    expect_miss();
    serve_refill(32'h8000_0000, D_LO, D_HI, 0, 0, 1'b0, D_LO);

    // fence_i together with a handshake: request served first, flush afterwards
    bus.fence_i   = 1'b1;
    bus.cache_req = 1'b1;
    bus.addr_inst = 32'h8000_0008;
    @(negedge clk);
    check("fence_hs_ready", bus.cache_ready, 1);
    @(posedge clk); #1;
    bus.fence_i   = 1'b0;
    bus.cache_req = 1'b0;
    expect_hit(D_HI);
    @(negedge clk);
    check("fence_hs_flush_ready", bus.cache_ready, 0);
    @(posedge clk); #1;
    start_fetch(32'h8000_0008);
    expect_miss();
    serve_refill(32'h8000_0000, D_LO, D_HI, 0, 0, 1'b0, D_HI);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage and the memory/bus bridge. It accepts one fetch request per handshake and returns the aligned 64-bit doubleword containing the requested PC. The fetch stage picks the 32-bit half itself. On a miss it refills a 16-byte line with a 2-beat burst from memory. It also supports a full invalidate for `fence.i`.

## Interface
Parameters:
- `ADDR_W`, 32, fetch/memory address width
- `INDEX_W`, 6, index bits; 64 lines
- `LINE_BEATS`, 2, 64-bit beats per line; fixed at 2 (offset bit = addr[3])

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `cache_req`  in  1  fetch request valid
- `addr_inst`  in  ADDR_W  fetch PC; addr[2:0] ignored
- `cache_ready`  out  1  request accepted when `cache_req && cache_ready`
- `cache_valid`  out  1  one-cycle pulse; `inst_i` valid
- `inst_i`  out  64  doubleword at addr[ADDR_W-1:3]
- `fence_i`  in  1  one-cycle invalidate-all pulse
- `mem_req`  out  1  line refill request
- `mem_addr`  out  ADDR_W  line-aligned address, addr[3:0]=0
- `mem_ready`  in  1  memory accepts `mem_req`
- `mem_rvalid`  in  1  refill beat valid
- `mem_rdata`  in  64  refill beat data; beat 0 is the low doubleword
- `mem_rlast`  in  1  last refill beat

## Operation
- Address split: tag = addr[ADDR_W-1:INDEX_W+4], index = addr[INDEX_W+3:4], beat = addr[3].
- Arrays:
  - valid[64], flop-based and cleared by reset and by flush.
  - tag[64] × (ADDR_W-10).
  - data[64][2] × 64.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE
  - `cache_ready`=1 unless a flush is pending.
  - On handshake: latch addr and go to LOOKUP.
- LOOKUP (compare latched tag and valid)
  - Hit:
    - `cache_valid`=1 with `inst_i` = data[index][beat].
    - `cache_ready`=1, so a new handshake this cycle stays in LOOKUP with the new addr; otherwise go to IDLE.
  - Miss: `cache_ready`=0; go to MISS_REQ.
- MISS_REQ
  - `mem_req`=1 with `mem_addr`={tag,index,4'b0}, held stable until `mem_ready`.
  - Then go to REFILL.
- REFILL
  - Each `mem_rvalid` writes data[index][beat counter] and increments the counter (1 bit).
  - The beat matching the requested beat is captured into the response register.
  - On `mem_rvalid && mem_rlast`: write the tag, set valid[index], go to RESP.
- RESP
  - `cache_valid`=1 with the captured doubleword.
  - `cache_ready`=0; go to IDLE.
- Flush
  - `fence_i` sets `flush_pending`.
  - The valid array clears in the first cycle the FSM is in IDLE with `flush_pending`. `cache_ready`=0 that cycle and the pending bit clears.
  - A flush arriving during LOOKUP, MISS_REQ, REFILL or RESP does not abort the refill. The refilled line is written and returned, then invalidated by the deferred flush.
- The block never drops data. The consumer must buffer `cache_valid` data that it cannot take (single-cycle pulse).
- Unexpected `mem_rvalid` outside REFILL is ignored.

## Timing
- Reset values:
  - state=IDLE; `cache_ready`=0 during reset, 1 in the first cycle after reset release.
  - `cache_valid`, `mem_req`, `flush_pending`, all valid bits = 0.
  - `inst_i`, `mem_addr` = 0.
- Hit latency:
  - Handshake in cycle N, `cache_valid` in N+1.
  - Back-to-back hits give 1 result per cycle.
- Miss latency:
  - Handshake in N, LOOKUP in N+1, `mem_req` from N+2.
  - `cache_valid` one cycle after the `mem_rlast` beat.
- The two refill beats may be non-consecutive; gaps are tolerated.
- Simultaneous `fence_i` and handshake in IDLE:
  - The handshake is accepted.
  - The flush is applied on the next IDLE entry, before the following handshake.
- Reset asserted mid-refill: abort immediately, no partial line valid, `mem_req` drops asynchronously.

## Structure
- `defines.v` gains `ICacheIndexW` and `ICacheLineBeats`, and reuses `MemAddrBus`/`INSTWide`.
- FSM state encodings are local parameters.
- One sub-module, `icache_data_ram`: 64×2×64 flop array, 1 read port (combinational on index/beat), 1 write port (index, beat, we, wdata). Tag and valid stay in the top level.

## Test plan
- Cold miss:
  - Stimulus: req 0x8000_0004 after reset; memory answers 0x1111_2222_3333_4444 / 0x5555_6666_7777_8888.
  - Response: `mem_addr`=0x8000_0000, `cache_valid` with 0x1111_2222_3333_4444 one cycle after `mem_rlast`.
- Hit stream: sequential reqs 0x8000_0000, 0x8000_0008, 0x8000_0000 after the line fill → three consecutive `cache_valid` pulses, no `mem_req`.
- Conflict miss: fill 0x8000_0000, then req 0x8000_0400 (same index) → refill. A re-request of 0x8000_0000 then misses again.
- Beat select with gapped beats:
  - Stimulus: req 0x8000_0018 (beat 1); `mem_rvalid` gap of 3 cycles between beats.
  - Response: returns beat 1 data; `mem_req` held until `mem_ready`.
- `fence_i` during REFILL:
  - Stimulus: flush pulse mid-refill of 0x8000_0000, then re-request the same address.
  - Response: the original request still returns refill data; the re-request misses.
- Reset mid-refill: `rst` low after beat 0 → outputs return to reset values; the following req 0x8000_0000 misses.
